// File: rtl/pwm_bus_arbiter_pkg.sv
// Shared definitions for the PWM register bus arbiter: FSM states, default
// bus widths and the PWM channel register offsets used by requesters.
package pwm_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic [7:0] REG_ENABLE = 8'h00;
    localparam logic [7:0] REG_PERIOD = 8'h04;
    localparam logic [7:0] REG_DUTY   = 8'h08;

endpackage

// File: rtl/pwm_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after rr_ptr_i, wrapping
// modulo N_REQ, so the last-served requester has the lowest priority.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       rr_ptr_i,
    output logic [2:0]       grant_o,
    output logic             found_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate so bit 0 of rot is the requester just after rr_ptr_i.
    always_comb begin
        dbl = {req_i, req_i} >> ({1'b0, rr_ptr_i} + 4'd1);
        rot = dbl[N_REQ-1:0];
    end

    always_comb begin
        int unsigned sum;
        grant_o = '0;
        found_o = 1'b0;
        sum     = 0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!found_o && rot[j]) begin
                found_o = 1'b1;
                sum     = 32'(rr_ptr_i) + 1 + j;
                grant_o = 3'(sum % N_REQ);
            end
        end
    end

endmodule

// File: rtl/pwm_bus_arbiter.sv
// Sole master of the PWM register bus: grants requesters round-robin, holds
// each transfer for HOLD_CYCLES clocks, then pulses a one-hot ack.
module pwm_bus_arbiter
    import pwm_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_wr,
    input  logic [N_REQ*AW-1:0] req_adr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic [2:0]          gnt_id,
    output logic [AW-1:0]       adr,
    output logic                cs,
    output logic                wr,
    output logic                rd,
    output logic [DW-1:0]       d_in,
    input  logic [DW-1:0]       d_out
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] PTR_RST   = 3'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [DW-1:0]    d_in_q, d_in_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;
    logic [2:0]       gnt_q, gnt_d, rr_q, rr_d;

    logic [2:0]       nxt_gnt;
    logic             nxt_found;
    logic [AW-1:0]    sel_adr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_wr;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i    (req),
        .rr_ptr_i (rr_q),
        .grant_o  (nxt_gnt),
        .found_o  (nxt_found)
    );

    always_comb begin
        sel_adr   = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (nxt_gnt == 3'(i)) begin
                sel_adr   = req_adr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_wr    = req_wr[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        adr_d   = adr_q;
        d_in_d  = d_in_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        cs_d    = cs_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (nxt_found) begin
                    gnt_d   = nxt_gnt;
                    adr_d   = sel_adr;
                    d_in_d  = sel_wr ? sel_wdata : '0;
                    cs_d    = 1'b1;
                    wr_d    = sel_wr;
                    rd_d    = ~sel_wr;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // wr_q still carries the latched direction on the final hold cycle.
                if (hold_q == 4'd0) begin
                    cs_d = 1'b0;
                    wr_d = 1'b0;
                    rd_d = 1'b0;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        ack_d[i] = (gnt_q == 3'(i));
                    end
                    if (!wr_q) begin
                        rdata_d = d_out;
                    end
                    state_d = S_DONE;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                rr_d    = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            adr_q   <= '0;
            d_in_q  <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            gnt_q   <= PTR_RST;
            rr_q    <= PTR_RST;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            adr_q   <= adr_d;
            d_in_q  <= d_in_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    assign ack    = ack_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_q;
    assign adr    = adr_q;
    assign cs     = cs_q;
    assign wr     = wr_q;
    assign rd     = rd_q;
    assign d_in   = d_in_q;

endmodule
